// File: rtl/cool_heat_system_if.sv
// Configuration/speed inputs and actuator outputs of the climate-control driver.
// The master side (register bank / bench) drives configuration and speed;
// the slave side (cool_heat_system) returns the applied level, mode and PWM.
interface cool_heat_system_if;
    logic [7:0] speed;
    logic [7:0] chs_conf;
    logic [3:0] chs_power;
    logic       chs_mode;
    logic       pwm_data;

    modport master (
        output speed,
        output chs_conf,
        input  chs_power,
        input  chs_mode,
        input  pwm_data
    );

    modport slave (
        input  speed,
        input  chs_conf,
        output chs_power,
        output chs_mode,
        output pwm_data
    );
endinterface

// File: rtl/cool_heat_system.sv
// Climate-control actuator driver: computes a 4-bit heat/cool power level from
// the configuration word and vehicle speed, optionally ramps it one step per
// PWM period, and drives a 16-clock PWM waveform plus a cool/heat mode line.
// Power and mode only change on the period boundary (cnt wrapping 15 -> 0).
module cool_heat_system (
    input  logic               clk,
    input  logic               arst,
    cool_heat_system_if.slave  bus
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] power_q;
    logic [3:0] power_d;
    logic       mode_q;
    logic       mode_d;

    logic       boundary;
    logic [4:0] target_sum;
    logic [3:0] target;

    logic       conf_off;
    logic       conf_mode;
    logic       conf_ramp;
    logic       conf_comp;
    logic [3:0] conf_level;

    assign conf_off   = bus.chs_conf[7];
    assign conf_mode  = bus.chs_conf[6];
    assign conf_ramp  = bus.chs_conf[5];
    assign conf_comp  = bus.chs_conf[4];
    assign conf_level = bus.chs_conf[3:0];

    assign boundary = (cnt_q == 4'd15);

    // Free-running period counter; wraps naturally at 16.
    always_comb begin
        cnt_d = cnt_q + 4'd1;
    end

    // Target level: requested level plus optional speed bonus, saturated at 15.
    always_comb begin
        target_sum = {1'b0, conf_level} + (conf_comp ? {3'b000, bus.speed[7:6]} : 5'd0);
        if (conf_off) begin
            target = 4'd0;
        end else if (target_sum > 5'd15) begin
            target = 4'd15;
        end else begin
            target = target_sum[3:0];
        end
    end

    // Boundary update of power/mode; with ramp the power is brought to zero
    // before the mode is allowed to flip, so the actuator never reverses under load.
    always_comb begin
        power_d = power_q;
        mode_d  = mode_q;
        if (boundary) begin
            if (!conf_ramp) begin
                power_d = target;
                mode_d  = conf_mode;
            end else if (conf_mode != mode_q) begin
                if (power_q != 4'd0) begin
                    power_d = power_q - 4'd1;
                end else begin
                    mode_d = conf_mode;
                end
            end else if (power_q < target) begin
                power_d = power_q + 4'd1;
            end else if (power_q > target) begin
                power_d = power_q - 4'd1;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q   <= 4'd0;
            power_q <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            power_q <= power_d;
            mode_q  <= mode_d;
        end
    end

    // PWM is a pure decode of registered state, so it is glitch-free relative to
    // the clock and goes low immediately when reset clears power_q.
    always_comb begin
        bus.pwm_data = (cnt_q < power_q);
    end

    assign bus.chs_power = power_q;
    assign bus.chs_mode  = mode_q;

endmodule

// File: tb/tb_cool_heat_system.sv
// Self-checking bench for cool_heat_system: directed scenarios from the
// functional description followed by randomized configuration traffic,
// all compared against a behavioural period/level model.
module tb_cool_heat_system;

    logic clk;
    logic arst;

    cool_heat_system_if bus ();

    cool_heat_system dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_cnt;
    int m_pow;
    int m_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int target_of(input int conf, input int spd);
        int t;
        if ((conf >> 7) & 1) return 0;
        t = (conf & 15) + (((conf >> 4) & 1) ? ((spd >> 6) & 3) : 0);
        return (t > 15) ? 15 : t;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_pow  = 0;
        m_mode = 0;
    endtask

    // One rising edge: advance the model with the inputs present at the edge,
    // then compare all outputs shortly after.
    task automatic tick();
        int conf;
        int spd;
        int tgt;
        int req;
        conf = int'(bus.chs_conf);
        spd  = int'(bus.speed);
        @(posedge clk);
        if (m_cnt == 15) begin
            tgt = target_of(conf, spd);
            req = (conf >> 6) & 1;
            if (((conf >> 5) & 1) == 0) begin
                m_pow  = tgt;
                m_mode = req;
            end else if (req != m_mode) begin
                if (m_pow > 0) m_pow = m_pow - 1;
                else           m_mode = req;
            end else if (m_pow < tgt) begin
                m_pow = m_pow + 1;
            end else if (m_pow > tgt) begin
                m_pow = m_pow - 1;
            end
        end
        m_cnt = (m_cnt + 1) % 16;
        #1;
        chk("power", int'(bus.chs_power), m_pow);
        chk("mode",  int'(bus.chs_mode),  m_mode);
        chk("pwm",   int'(bus.pwm_data),  (m_cnt < m_pow) ? 1 : 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Runs one full period and also checks the PWM shape against the expected duty.
    task automatic period_duty(input string tag, input int duty);
        int highs;
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i < 15) highs += int'(bus.pwm_data);
        end
        // the 16th tick lands on the boundary, whose output belongs to the next period
        chk(tag, highs, (duty > 15) ? 15 : ((duty < 1) ? 0 : duty - 1));
    endtask

    task automatic apply_reset();
        #2;
        arst = 1'b1;
        #1;
        model_reset();
        chk("rst_power", int'(bus.chs_power), 0);
        chk("rst_mode",  int'(bus.chs_mode),  0);
        chk("rst_pwm",   int'(bus.pwm_data),  0);
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        arst         = 1'b1;
        bus.chs_conf = 8'h00;
        bus.speed    = 8'h00;
        #12;
        model_reset();
        chk("por_power", int'(bus.chs_power), 0);
        chk("por_mode",  int'(bus.chs_mode),  0);
        chk("por_pwm",   int'(bus.pwm_data),  0);
        @(negedge clk);
        arst = 1'b0;

        // plain level 7, cool, no ramp
        bus.chs_conf = 8'h47;
        bus.speed    = 8'h78;
        ticks(15);
        chk("tp1_pre", int'(bus.chs_power), 0);
        tick();
        chk("tp1_pow",  int'(bus.chs_power), 7);
        chk("tp1_mode", int'(bus.chs_mode),  1);
        period_duty("tp1_duty", 7);

        // ramp with compensation: 7 -> 8 -> 9 -> hold
        bus.chs_conf = 8'h76;
        bus.speed    = 8'hEE;
        ticks(16);
        chk("tp2_s1", int'(bus.chs_power), 8);
        ticks(16);
        chk("tp2_s2", int'(bus.chs_power), 9);
        ticks(16);
        chk("tp2_hold", int'(bus.chs_power), 9);
        period_duty("tp2_duty", 9);

        // saturation 15 + 3
        bus.chs_conf = 8'h1F;
        bus.speed    = 8'hFF;
        ticks(16);
        chk("tp3_sat", int'(bus.chs_power), 15);
        period_duty("tp3_duty", 15);

        // off keeps the mode, power drops to zero
        bus.chs_conf = 8'h47;
        ticks(16);
        bus.chs_conf = 8'hC7;
        ticks(16);
        chk("tp4_off",  int'(bus.chs_power), 0);
        chk("tp4_mode", int'(bus.chs_mode),  1);
        period_duty("tp4_duty", 0);

        // ramped mode reversal from 9 cool to 6 heat
        bus.chs_conf = 8'h49;
        ticks(16);
        chk("tp5_start", int'(bus.chs_power), 9);
        bus.chs_conf = 8'h26;
        for (int k = 8; k >= 0; k--) begin
            ticks(16);
            chk("tp5_down", int'(bus.chs_power), k);
            chk("tp5_keep", int'(bus.chs_mode), 1);
        end
        ticks(16);
        chk("tp5_flip", int'(bus.chs_mode), 0);
        chk("tp5_zero", int'(bus.chs_power), 0);
        for (int k = 1; k <= 6; k++) begin
            ticks(16);
            chk("tp5_up", int'(bus.chs_power), k);
        end

        // mid-period reset, then first update again on the 16th edge
        bus.chs_conf = 8'h49;
        ticks(16);
        chk("tp6_pre", int'(bus.chs_power), 9);
        ticks(5);
        apply_reset();
        ticks(15);
        chk("tp6_wait", int'(bus.chs_power), 0);
        tick();
        chk("tp6_first", int'(bus.chs_power), 9);

        // randomized traffic, inputs changed at arbitrary cycles
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.chs_conf = 8'($urandom);
            if ($urandom_range(0, 9) == 0)  bus.speed    = 8'($urandom);
            if ($urandom_range(0, 999) == 0) apply_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cool_heat_system.md
# cool_heat_system

Climate-control actuator driver. Takes an 8-bit configuration word and the current vehicle speed, computes a 4-bit heating/cooling power level with optional speed compensation and soft ramping, and drives the actuator with a 16-cycle PWM waveform plus a mode line (cool/heat). It sits between the configuration register bank and the blower/compressor driver stage.

## Interface
- No parameters; all widths are fixed.
- Reset: one clock; reset is asynchronous and active-high.
- clk  input  1  system clock; all state updates on the rising edge.
- arst  input  1  asynchronous, active-high reset.
- speed  input  8  vehicle speed, unsigned; only speed[7:6] is used.
- chs_conf  input  8  configuration word:
  - [7] off: forces target power to 0.
  - [6] mode request: 1 = cool, 0 = heat.
  - [5] ramp enable.
  - [4] speed-compensation enable.
  - [3:0] requested level.
- chs_power  output  4  applied power level, registered.
- chs_mode  output  1  applied mode, registered: 1 = cool, 0 = heat.
- pwm_data  output  1  PWM drive signal.

## Operation
- Period counter cnt (4-bit) is free-running: 0..15, then wraps to 0. One PWM period is 16 clocks.
- Target level:
  - If chs_conf[7] = 1, target = 0.
  - Otherwise target = chs_conf[3:0] + (chs_conf[4] ? speed[7:6] : 0).
  - Computed 5 bits wide, then saturated to 15.
- Boundary update: happens on the edge where cnt = 15 (cnt wraps to 0). Inputs are sampled only at this edge; changes at other times have no effect until the next boundary.
- Ramp disabled (chs_conf[5] = 0) at a boundary:
  - chs_power <= target.
  - chs_mode <= chs_conf[6].
- Ramp enabled (chs_conf[5] = 1) at a boundary, checked in this order:
  - Mode request differs from chs_mode and chs_power > 0: chs_power decrements by 1.
  - Mode request differs from chs_mode and chs_power = 0: chs_mode flips to the request; chs_power stays 0.
  - Modes match: chs_power moves one step toward target (+1, −1, or hold if equal).
- pwm_data = 1 iff cnt < chs_power, decoded from registered values.
  - chs_power 0: pwm_data constantly 0.
  - chs_power 15: pwm_data is 1 for 15 of 16 cycles.
  - The high phase always starts at cnt = 0.

## Timing
- Reset values, while arst is high and immediately after deassertion: cnt=0, chs_power=0, chs_mode=0, pwm_data=0.
- Reset asserted mid-period forces all of the above asynchronously; the period restarts from cnt=0 after deassertion.
- The first boundary after reset release occurs on the 16th rising edge. chs_power and chs_mode change only on boundary edges.
- Latency from a config change to an applied level: up to 16 cycles without ramp; ramp adds one period per unit step.
- A mode change under ramp takes chs_power + 1 periods before the new mode appears, then one more period per step up.
- pwm_data reflects a new chs_power in the cycle directly after the boundary edge (cnt = 0).
- Saturation boundary: level 15 with compensation 3 gives 15, not a wrapped 2.

## Test plan
- Reset, then chs_conf=0x47, speed=0x78 → after the 16th edge, chs_power=7 and chs_mode=1; pwm_data high for cnt 0..6, low for cnt 7..15, repeating every 16 cycles.
- From that state, chs_conf=0x76, speed=0xEE (ramp, compensation on, target 6+3=9) → chs_power steps 8 then 9 at consecutive boundaries, then holds 9; pwm duty 9/16.
- chs_conf=0x1F, speed=0xFF → chs_power=15 (saturated) after one boundary; pwm_data low only at cnt=15.
- chs_conf=0xC7 (off) → chs_power=0 at the next boundary; pwm_data constant 0; chs_mode still 1.
- Starting from power 9 in cool mode, apply chs_conf=0x26 (heat, ramp, level 6):
  - chs_power falls 8..0 over 9 boundaries.
  - At the next boundary chs_mode becomes 0 with power 0.
  - chs_power then rises 1..6 over 6 boundaries.
- Assert arst mid-period with chs_power=9 → chs_power, chs_mode and pwm_data are 0 immediately without a clock; after release, the first update is again on the 16th edge.
